line_memory: RTL and testbench

- Backing memory on the downstream side of the split I/D cache. It serves whole 4-word (64-bit) line reads on the instruction port, and line reads and writes on the data port.
- Each port has a fixed, parameterised latency and raises a one-cycle ready pulse when its transfer completes.
- Both ports access one shared word array. They run independently and concurrently.

---
 rtl/line_memory.sv | 181 ++++++++++++++++++
 tb/tb_line_memory.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_memory.sv
// Shared line-granular backing memory with an independent read-only I-port and
// read/write D-port. Optional access counters are enabled with `LINE_MEMORY_STATS_EN.
module line_memory #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 4,
  parameter int MEM_LINES  = 64
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            i_readM,
  input  logic                            i_writeM,
  input  logic [WORD_SIZE-1:0]            i_addressM,
  inout  wire  [WORD_SIZE*LINE_WORDS-1:0] i_dataM,
  output logic                            i_ready,
  input  logic                            d_readM,
  input  logic                            d_writeM,
  input  logic [WORD_SIZE-1:0]            d_addressM,
  inout  wire  [WORD_SIZE*LINE_WORDS-1:0] d_dataM,
  output logic                            d_ready
`ifdef LINE_MEMORY_STATS_EN
  ,
  output logic [15:0]                     i_read_cnt,
  output logic [15:0]                     d_read_cnt,
  output logic [15:0]                     d_write_cnt
`endif
);

  localparam int LINE_BITS = WORD_SIZE * LINE_WORDS;
  localparam int IDX_W     = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam logic [3:0] LAST = 4'(LATENCY);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY     = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;
  localparam logic [1:0] WAIT_LOW = 2'd3;

  // MEM_LINES is a power of two, so the low line-address bits give the wrap.
  logic [LINE_BITS-1:0] mem_q [MEM_LINES];

  logic [1:0]           iState_q, iState_d;
  logic [3:0]           iCnt_q, iCnt_d;
  logic [IDX_W-1:0]     iIdx_q, iIdx_d;
  logic [LINE_BITS-1:0] iLine_q, iLine_d;
  logic                 iFinish;

  logic [1:0]           dState_q, dState_d;
  logic [3:0]           dCnt_q, dCnt_d;
  logic [IDX_W-1:0]     dIdx_q, dIdx_d;
  logic                 dWrite_q, dWrite_d;
  logic [LINE_BITS-1:0] dLine_q, dLine_d;
  logic                 dFinish;
  logic                 dRequest;

  logic unusedInputs;
  assign unusedInputs = ^{i_writeM, i_addressM, d_addressM, i_dataM};

  assign iFinish  = (iState_q == BUSY) && (iCnt_q == LAST);
  assign dFinish  = (dState_q == BUSY) && (dCnt_q == LAST);
  assign dRequest = d_readM | d_writeM;

  always_comb begin
    iState_d = iState_q;
    iCnt_d   = iCnt_q;
    iIdx_d   = iIdx_q;
    iLine_d  = iLine_q;
    case (iState_q)
      IDLE: begin
        if (i_readM) begin
          iState_d = BUSY;
          iCnt_d   = 4'd1;
          iIdx_d   = i_addressM[2 +: IDX_W];
        end
      end
      BUSY: begin
        if (iFinish) begin
          iState_d = DONE;
          iCnt_d   = 4'd0;
          iLine_d  = mem_q[iIdx_q];
        end else begin
          iCnt_d = iCnt_q + 4'd1;
        end
      end
      DONE:     iState_d = i_readM ? WAIT_LOW : IDLE;
      WAIT_LOW: if (!i_readM) iState_d = IDLE;
      default:  iState_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iState_q <= IDLE;
      iCnt_q   <= 4'd0;
      iIdx_q   <= '0;
      iLine_q  <= '0;
    end else begin
      iState_q <= iState_d;
      iCnt_q   <= iCnt_d;
      iIdx_q   <= iIdx_d;
      iLine_q  <= iLine_d;
    end
  end

  // A write outranks a read when the requester raises both.
  always_comb begin
    dState_d = dState_q;
    dCnt_d   = dCnt_q;
    dIdx_d   = dIdx_q;
    dWrite_d = dWrite_q;
    dLine_d  = dLine_q;
    case (dState_q)
      IDLE: begin
        if (dRequest) begin
          dState_d = BUSY;
          dCnt_d   = 4'd1;
          dIdx_d   = d_addressM[2 +: IDX_W];
          dWrite_d = d_writeM;
        end
      end
      BUSY: begin
        if (dFinish) begin
          dState_d = DONE;
          dCnt_d   = 4'd0;
          if (!dWrite_q) dLine_d = mem_q[dIdx_q];
        end else begin
          dCnt_d = dCnt_q + 4'd1;
        end
      end
      DONE:     dState_d = dRequest ? WAIT_LOW : IDLE;
      WAIT_LOW: if (!dRequest) dState_d = IDLE;
      default:  dState_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dState_q <= IDLE;
      dCnt_q   <= 4'd0;
      dIdx_q   <= '0;
      dWrite_q <= 1'b0;
      dLine_q  <= '0;
    end else begin
      dState_q <= dState_d;
      dCnt_q   <= dCnt_d;
      dIdx_q   <= dIdx_d;
      dWrite_q <= dWrite_d;
      dLine_q  <= dLine_d;
    end
  end

  // Array contents survive reset; a reset before the final BUSY edge drops the write.
  always_ff @(posedge clk) begin
    if (dFinish && dWrite_q) mem_q[dIdx_q] <= d_dataM;
  end

  assign i_ready = (iState_q == DONE);
  assign d_ready = (dState_q == DONE);
  assign i_dataM = (iState_q == DONE) ? iLine_q : 'z;
  assign d_dataM = ((dState_q == DONE) && !dWrite_q) ? dLine_q : 'z;

`ifdef LINE_MEMORY_STATS_EN
  logic [15:0] iReadCnt_q, dReadCnt_q, dWriteCnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iReadCnt_q  <= 16'd0;
      dReadCnt_q  <= 16'd0;
      dWriteCnt_q <= 16'd0;
    end else begin
      if (iFinish)              iReadCnt_q  <= iReadCnt_q + 16'd1;
      if (dFinish && !dWrite_q) dReadCnt_q  <= dReadCnt_q + 16'd1;
      if (dFinish && dWrite_q)  dWriteCnt_q <= dWriteCnt_q + 16'd1;
    end
  end

  assign i_read_cnt  = iReadCnt_q;
  assign d_read_cnt  = dReadCnt_q;
  assign d_write_cnt = dWriteCnt_q;
`endif

endmodule

// File: tb/tb_line_memory.sv
// Bench for line_memory: directed scenarios plus randomized traffic against a
// line-array reference model. Stats counters are checked when `LINE_MEMORY_STATS_EN is set.
module tb_line_memory;

  localparam int LAT = 4;
  localparam logic [63:0] SENTINEL = 64'hA5A5_5A5A_C3C3_3C3C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        i_readM, i_writeM, d_readM, d_writeM;
  logic [15:0] i_addressM, d_addressM;
  wire  [63:0] i_dataM, d_dataM;
  logic        i_ready, d_ready;
  logic        iDriveEn, dDriveEn;
  logic [63:0] iDrive, dDrive;

  assign i_dataM = iDriveEn ? iDrive : 'z;
  assign d_dataM = dDriveEn ? dDrive : 'z;

`ifdef LINE_MEMORY_STATS_EN
  logic [15:0] i_read_cnt, d_read_cnt, d_write_cnt;
`endif

  int nChecks = 0;
  int nFails  = 0;
  int nIRead  = 0;
  int nDRead  = 0;
  int nDWrite = 0;
  logic [63:0] refMem [64];

  line_memory #(.WORD_SIZE(16), .LINE_WORDS(4), .LATENCY(LAT), .MEM_LINES(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_readM(i_readM), .i_writeM(i_writeM), .i_addressM(i_addressM),
    .i_dataM(i_dataM), .i_ready(i_ready),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_addressM(d_addressM),
    .d_dataM(d_dataM), .d_ready(d_ready)
`ifdef LINE_MEMORY_STATS_EN
    , .i_read_cnt(i_read_cnt), .d_read_cnt(d_read_cnt), .d_write_cnt(d_write_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int lineOf(input logic [15:0] a);
    return (int'(a) / 4) % 64;
  endfunction

  // Nobody but the bench drives the bus now, so the sentinel must read back intact.
  task automatic checkFloating(input string tag, input bit onIPort);
    if (onIPort) begin
      iDrive = SENTINEL; iDriveEn = 1'b1; #1;
      checkOutput(tag, i_dataM, SENTINEL);
      iDriveEn = 1'b0;
    end else begin
      dDrive = SENTINEL; dDriveEn = 1'b1; #1;
      checkOutput(tag, d_dataM, SENTINEL);
      dDriveEn = 1'b0;
    end
  endtask

  task automatic checkStats(input string tag);
`ifdef LINE_MEMORY_STATS_EN
    checkOutput({tag, " i_read_cnt"}, 64'(i_read_cnt), 64'(nIRead));
    checkOutput({tag, " d_read_cnt"}, 64'(d_read_cnt), 64'(nDRead));
    checkOutput({tag, " d_write_cnt"}, 64'(d_write_cnt), 64'(nDWrite));
`else
    if (tag.len() < 0) $display("[TB] %s", tag);
`endif
  endtask

  // kind: 0 I read, 1 D read, 2 D write, 3 D read+write raised together
  task automatic applyStimulus(input int kind, input logic [15:0] addr, input logic [63:0] wdata,
                               input int holdCycles, input string tag);
    int n = 0;
    bit seen = 1'b0;
    int ln = lineOf(addr);
    bit isWrite = (kind >= 2);
    bit onI = (kind == 0);
    if (onI) begin
      i_readM = 1'b1; i_addressM = addr;
    end else begin
      d_addressM = addr;
      d_readM  = (kind == 1) || (kind == 3);
      d_writeM = isWrite;
      if (isWrite) begin dDrive = wdata; dDriveEn = 1'b1; end
    end
    while (!seen && n < 40) begin
      tick; n++;
      seen = onI ? i_ready : d_ready;
    end
    checkOutput({tag, " latency"}, 64'(n), 64'(LAT + 1));
    if (onI)          checkOutput({tag, " data"}, i_dataM, refMem[ln]);
    else if (isWrite) checkOutput({tag, " bus undriven"}, d_dataM, wdata);
    else              checkOutput({tag, " data"}, d_dataM, refMem[ln]);
    if (isWrite) begin refMem[ln] = wdata; nDWrite++; end
    else if (onI) nIRead++;
    else nDRead++;
    dDriveEn = 1'b0;
    for (int k = 0; k < holdCycles; k++) begin
      tick;
      checkOutput({tag, " held no retrigger"}, 64'(onI ? i_ready : d_ready), 64'd0);
    end
    i_readM = 1'b0; d_readM = 1'b0; d_writeM = 1'b0;
    tick;
    checkOutput({tag, " ready low"}, 64'(onI ? i_ready : d_ready), 64'd0);
    checkFloating({tag, " bus released"}, onI);
  endtask

  // D write starts first; the I read is raised off cycles later.
  task automatic applyOverlap(input logic [15:0] dAddr, input logic [15:0] iAddr,
                              input logic [63:0] wdata, input int off, input string tag);
    int n = 0, dAt = 0, iAt = 0;
    bit dSeen = 1'b0, iSeen = 1'b0;
    int dLn = lineOf(dAddr);
    int iLn = lineOf(iAddr);
    logic [63:0] expI;
    expI = (dLn == iLn && off > 0) ? wdata : refMem[iLn];
    d_writeM = 1'b1; d_addressM = dAddr; dDrive = wdata; dDriveEn = 1'b1;
    while ((!dSeen || !iSeen) && n < 40) begin
      if (n == off) begin i_readM = 1'b1; i_addressM = iAddr; end
      tick; n++;
      if (d_ready && !dSeen) begin
        dSeen = 1'b1; dAt = n;
        d_writeM = 1'b0; dDriveEn = 1'b0;
      end
      if (i_ready && !iSeen) begin
        iSeen = 1'b1; iAt = n;
        checkOutput({tag, " I data"}, i_dataM, expI);
        i_readM = 1'b0;
      end
    end
    checkOutput({tag, " D latency"}, 64'(dAt), 64'(LAT + 1));
    checkOutput({tag, " I latency"}, 64'(iAt), 64'(off + LAT + 1));
    refMem[dLn] = wdata;
    nDWrite++; nIRead++;
    tick;
    checkOutput({tag, " readies low"}, 64'({i_ready, d_ready}), 64'd0);
  endtask

  initial begin
    logic [15:0] addrA, addrB;
    logic [63:0] data;
    int line;

    reset_n = 1'b0;
    i_readM = 1'b0; i_writeM = 1'b0; i_addressM = '0;
    d_readM = 1'b0; d_writeM = 1'b0; d_addressM = '0;
    iDriveEn = 1'b0; dDriveEn = 1'b0; iDrive = '0; dDrive = '0;
    #2;
    checkOutput("reset i_ready", 64'(i_ready), 64'd0);
    checkOutput("reset d_ready", 64'(d_ready), 64'd0);
    checkFloating("reset i bus", 1'b1);
    checkFloating("reset d bus", 1'b0);
    checkStats("reset");
    tick; tick;
    reset_n = 1'b1;
    tick;

    applyStimulus(2, 16'h000C, 64'h0004_0003_0002_0001, 0, "preload line3");
    applyStimulus(2, 16'h0014, 64'h0000_0000_0000_1111, 0, "preload line5");
    applyStimulus(2, 16'h001C, 64'h7777_6666_5555_4444, 0, "preload line7");
    for (int l = 8; l < 16; l++)
      applyStimulus(2, 16'(l * 4), {$urandom, $urandom}, 0, "preload rand");

    // The held I read must pulse exactly once; i_writeM has no effect on the I-port.
    i_writeM = 1'b1;
    applyStimulus(0, 16'h000C, '0, 3, "I read line3 held");
    i_writeM = 1'b0;

    applyStimulus(2, 16'h0010, 64'hDEAD_BEEF_CAFE_F00D, 0, "D write line4");
    applyStimulus(1, 16'h0012, '0, 1, "D read line4");

    applyOverlap(16'h0014, 16'h0014, 64'h5555_AAAA_5555_AAAA, 0, "collide line5");
    applyStimulus(0, 16'h0016, '0, 0, "I read line5 after");

    // Reset two edges into a write must neither complete nor commit.
    d_writeM = 1'b1; d_addressM = 16'h001C; dDrive = 64'hBAD0_BAD0_BAD0_BAD0; dDriveEn = 1'b1;
    tick; tick;
    reset_n = 1'b0;
    #1;
    checkOutput("abort ready at reset", 64'(d_ready), 64'd0);
    d_writeM = 1'b0; dDriveEn = 1'b0;
    nIRead = 0; nDRead = 0; nDWrite = 0;
    for (int k = 0; k < LAT + 2; k++) begin
      tick;
      checkOutput("abort ready in reset", 64'(d_ready), 64'd0);
    end
    checkStats("after abort reset");
    reset_n = 1'b1;
    tick;
    checkOutput("abort ready after release", 64'(d_ready), 64'd0);
    applyStimulus(1, 16'h001C, '0, 0, "D read line7 unchanged");

    applyStimulus(3, 16'h0100, 64'h0BAD_F00D_1234_5678, 0, "D both wrap line0");
    applyStimulus(0, 16'h0000, '0, 0, "I read line0");

    for (int it = 0; it < 24; it++) begin
      line  = 8 + int'($urandom_range(0, 7));
      addrA = {8'($urandom), 6'(line), 2'($urandom)};
      data  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: applyStimulus(0, addrA, '0, int'($urandom_range(0, 2)), "rand I read");
        1: applyStimulus(1, addrA, '0, int'($urandom_range(0, 2)), "rand D read");
        2: applyStimulus(2, addrA, data, int'($urandom_range(0, 2)), "rand D write");
        default: begin
          line  = ($urandom_range(0, 1) == 0) ? line : 8 + int'($urandom_range(0, 7));
          addrB = {8'($urandom), 6'(line), 2'($urandom)};
          applyOverlap(addrA, addrB, data, int'($urandom_range(0, 2)), "rand overlap");
        end
      endcase
    end

    checkStats("final");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
